// File: rtl/pipe_hazard_ctrl_if.sv
// Bus bundle between the pipeline datapath and the hazard controller.
// The datapath (master) drives the hazard/memory status lines; the
// controller (slave) drives the register enables, the state and the
// diagnostic outputs.
interface pipe_hazard_ctrl_if;
    // Hazard and memory status from the datapath.
    logic        ld_use;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_ready;
    logic        err_clr;

    // Pipeline register controls back to the datapath.
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_we;
    logic        idex_bubble;
    logic        exmem_we;
    logic        memwb_we;

    // Observability.
    logic [1:0]  ctrl_state;
    logic        mem_err;
    logic [15:0] stall_cycles;

    modport master (
        output ld_use, imem_ready, dmem_req, dmem_ready, err_clr,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_bubble,
               exmem_we, memwb_we, ctrl_state, mem_err, stall_cycles
    );

    modport slave (
        input  ld_use, imem_ready, dmem_req, dmem_ready, err_clr,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_bubble,
               exmem_we, memwb_we, ctrl_state, mem_err, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage pipeline.
// Generates PC / pipeline-register write enables, IF/ID flush and ID/EX
// bubble from load-use, fetch-wait and data-memory-wait conditions, with a
// wait timeout that parks the pipeline in an error state until err_clr.
//
// Handshake: imem_ready / dmem_ready are level "data available this cycle"
// qualifiers sampled together with the enables; an access is complete on the
// cycle its ready is high. All enables are combinational in the current
// state and inputs, so a stall freezes the pipeline in the cycle detected.
//
// Optional feature: define HAZARD_PERF_EN to build the saturating
// stall-cycle performance counter; otherwise stall_cycles is tied to zero.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic          clock,
    input  logic          resetn,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        FETCHWAIT = 2'b01,
        MEMWAIT   = 2'b10,
        ERR       = 2'b11
    } state_t;

    // Last wait_cnt value allowed before a timeout fires.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;

    logic mem_stall;
    logic fetch_stall;

    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_bubble;
    logic exmem_we;
    logic memwb_we;

    assign mem_stall   = bus.dmem_req & ~bus.dmem_ready;
    assign fetch_stall = ~bus.imem_ready;

    // State register; reset abandons any wait in progress.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; a completed data access beats the timeout.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_next = MEMWAIT;
                end else if (fetch_stall) begin
                    state_next = FETCHWAIT;
                end
            end
            MEMWAIT: begin
                if (bus.dmem_ready) begin
                    state_next = bus.imem_ready ? RUN : FETCHWAIT;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = ERR;
                end
            end
            FETCHWAIT: begin
                if (mem_stall) begin
                    state_next = MEMWAIT;
                end else if (bus.imem_ready) begin
                    state_next = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = ERR;
                end
            end
            ERR: begin
                if (bus.err_clr) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Wait counter: counts cycles spent in a wait state, restarts on any
    // state change so every wait gets the full TIMEOUT budget.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= 8'd0;
        end else if (state_next != state) begin
            wait_cnt <= 8'd0;
        end else if (state == MEMWAIT || state == FETCHWAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Output decode by priority: ERR, memory stall, load-use, fetch stall.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_we     = 1'b1;
        idex_bubble = 1'b0;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        if (state == ERR || mem_stall) begin
            // Freeze the whole pipeline.
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
        end else if (bus.ld_use) begin
            // Hold IF and ID, let a bubble into EX; the held ID word covers
            // any pending fetch so no flush is needed.
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else if (fetch_stall) begin
            // Keep fetching the same PC; feed a NOP into ID meanwhile.
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    assign bus.pc_we       = pc_we;
    assign bus.ifid_we     = ifid_we;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_we     = idex_we;
    assign bus.idex_bubble = idex_bubble;
    assign bus.exmem_we    = exmem_we;
    assign bus.memwb_we    = memwb_we;
    assign bus.ctrl_state  = state;
    assign bus.mem_err     = (state == ERR);

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt;

    // Stall counter: one count per cycle the PC is held, saturating.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= 16'h0000;
        end else if (!pc_we && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end

    assign bus.stall_cycles = stall_cnt;
`else
    assign bus.stall_cycles = 16'h0000;
`endif

endmodule
